// File: rtl/yutorina_cpu_pkg.sv
// Shared CPU definitions: pipeline bus encodings, controller states,
// SPR addresses and STATUS bit positions.
package yutorina_cpu_pkg;

  // Memory operation carried by the EX stage.
  typedef logic [1:0] mem_op_bus_t;
  localparam mem_op_bus_t MEM_OP_NOP = 2'd0;
  localparam mem_op_bus_t MEM_OP_LDW = 2'd1;
  localparam mem_op_bus_t MEM_OP_STW = 2'd2;

  // Exception codes carried by the MEM stage.
  typedef logic [2:0] exp_bus_t;
  localparam exp_bus_t EXP_NONE       = 3'd0;
  localparam exp_bus_t EXP_IRQ        = 3'd1;
  localparam exp_bus_t EXP_UNDEF_INSN = 3'd2;
  localparam exp_bus_t EXP_OVERFLOW   = 3'd3;
  localparam exp_bus_t EXP_MISS_ALIGN = 3'd4;
  localparam exp_bus_t EXP_TRAP       = 3'd5;
  localparam exp_bus_t EXP_PRV_INSN   = 3'd6;

  // Control operations carried by the MEM stage.
  typedef logic [1:0] ctrl_op_bus_t;
  localparam ctrl_op_bus_t CTRL_NOP  = 2'd0;
  localparam ctrl_op_bus_t CTRL_LSR  = 2'd1;
  localparam ctrl_op_bus_t CTRL_SSR  = 2'd2;
  localparam ctrl_op_bus_t CTRL_ERET = 2'd3;

  // Controller states.
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_EXC   = 2'd2,
    ST_ERET  = 2'd3
  } cpu_state_t;

  // SPR addresses.
  localparam logic [4:0] SPR_STATUS     = 5'd0;
  localparam logic [4:0] SPR_EPC        = 5'd1;
  localparam logic [4:0] SPR_CAUSE      = 5'd2;
  localparam logic [4:0] SPR_EXP_VECTOR = 5'd3;

  // STATUS bit positions.
  localparam int STATUS_M   = 0;
  localparam int STATUS_PM  = 1;
  localparam int STATUS_IE  = 2;
  localparam int STATUS_PIE = 3;

  localparam logic MODE_KERNEL = 1'b1;
  localparam logic MODE_USER   = 1'b0;

  function automatic logic is_mem_read(input mem_op_bus_t op);
    return op == MEM_OP_LDW;
  endfunction

endpackage

// File: rtl/yutorina_spr.sv
// Special-purpose register file: STATUS, EPC, CAUSE, EXP_VECTOR storage,
// exception/ERET side effects and the combinational read mux.
// With YUTORINA_IRQ_EN defined, STATUS.IE is exported for interrupt gating.
module yutorina_spr
  import yutorina_cpu_pkg::*;
#(
  parameter logic [29:0] EXP_VECTOR_INIT = 30'h4
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        exp_we,
  input  exp_bus_t    exp_code,
  input  logic [29:0] exp_epc,
  input  logic        eret_we,
  input  logic        ssr_we,
  input  logic [4:0]  ssr_addr,
  input  logic [31:0] ssr_data,
  input  logic [4:0]  r_addr,
  output logic [31:0] r_data,
  output logic        mode,
`ifdef YUTORINA_IRQ_EN
  output logic        ie,
`endif
  output logic [29:0] epc,
  output logic [29:0] exp_vector
);

  logic [3:0] status;
  exp_bus_t   cause;

  // SPR storage; exception entry and ERET take precedence over a software write.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      status     <= 4'b0001;
      epc        <= '0;
      cause      <= EXP_NONE;
      exp_vector <= EXP_VECTOR_INIT;
    end else if (exp_we) begin
      cause              <= exp_code;
      epc                <= exp_epc;
      status[STATUS_PM]  <= status[STATUS_M];
      status[STATUS_M]   <= MODE_KERNEL;
      status[STATUS_PIE] <= status[STATUS_IE];
      status[STATUS_IE]  <= 1'b0;
    end else if (eret_we) begin
      status[STATUS_M]  <= status[STATUS_PM];
      status[STATUS_IE] <= status[STATUS_PIE];
    end else if (ssr_we) begin
      case (ssr_addr)
        SPR_STATUS:     status     <= ssr_data[3:0];
        SPR_EPC:        epc        <= ssr_data[31:2];
        SPR_CAUSE:      cause      <= ssr_data[2:0];
        SPR_EXP_VECTOR: exp_vector <= ssr_data[31:2];
        default: ;
      endcase
    end
  end

  // Read mux; a same-cycle SSR is deliberately not bypassed.
  always_comb begin
    r_data = '0;
    case (r_addr)
      SPR_STATUS:     r_data = {28'b0, status};
      SPR_EPC:        r_data = {epc, 2'b00};
      SPR_CAUSE:      r_data = {29'b0, cause};
      SPR_EXP_VECTOR: r_data = {exp_vector, 2'b00};
      default:        r_data = '0;
    endcase
  end

  assign mode = status[STATUS_M];
`ifdef YUTORINA_IRQ_EN
  assign ie = status[STATUS_IE];
`endif

endmodule

// File: rtl/yutorina_cpu_ctrl.sv
// Pipeline controller: exception/ERET sequencing, load-use hazard and
// bus-wait stalls. Optional level interrupt input enabled by YUTORINA_IRQ_EN.
//
// state    | meaning
// ST_RESET | first cycle after reset: flush everything, fetch RESET_VECTOR
// ST_RUN   | normal operation, exceptions/ERET/SSR accepted from MEM
// ST_EXC   | one cycle after exception entry, pipeline refilling
// ST_ERET  | one cycle after ERET, pipeline refilling
module yutorina_cpu_ctrl
  import yutorina_cpu_pkg::*;
#(
  parameter logic [29:0] RESET_VECTOR    = 30'h0,
  parameter logic [29:0] EXP_VECTOR_INIT = 30'h4
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic [4:0]   id_gpr_r_addr1,
  input  logic [4:0]   id_gpr_r_addr2,
  input  logic [4:0]   ex_w_addr,
  input  mem_op_bus_t  ex_mem_op,
  input  logic         ex_gpr_we_,
  input  logic         mem_en,
  input  logic [29:0]  mem_pc,
  input  exp_bus_t     mem_exp_code,
  input  ctrl_op_bus_t mem_ctrl_op,
  input  logic [4:0]   mem_spr_addr,
  input  logic [31:0]  mem_spr_data,
  input  logic [4:0]   spr_r_addr,
  input  logic         if_busy,
  input  logic         mem_busy,
`ifdef YUTORINA_IRQ_EN
  input  logic         irq,
`endif
  output logic [31:0]  spr_r_data,
  output logic         mode,
  output logic         if_stall,
  output logic         id_stall,
  output logic         ex_stall,
  output logic         mem_stall,
  output logic         if_flush,
  output logic         id_flush,
  output logic         ex_flush,
  output logic         mem_flush,
  output logic [29:0]  flush_pc
);

  cpu_state_t  state, next_state;
  logic [3:0]  stall_v, flush_v;
  logic        exp_we, eret_we, ssr_we;
  logic        sync_exc, exp_take, eret_req, ssr_req, load_use;
  exp_bus_t    exp_code;
  logic [29:0] exp_epc;
  logic [29:0] epc, exp_vector;

  assign sync_exc = mem_en && (mem_exp_code != EXP_NONE);
  assign eret_req = mem_en && (mem_ctrl_op == CTRL_ERET);
  assign ssr_req  = mem_en && (mem_ctrl_op == CTRL_SSR);
  assign load_use = is_mem_read(ex_mem_op) && !ex_gpr_we_ && (ex_w_addr != 5'd0) &&
                    ((ex_w_addr == id_gpr_r_addr1) || (ex_w_addr == id_gpr_r_addr2));
  // A trap returns past itself; every other fault re-executes the faulting word.
  assign exp_epc  = (sync_exc && mem_exp_code == EXP_TRAP) ? mem_pc + 30'd1 : mem_pc;

`ifdef YUTORINA_IRQ_EN
  logic status_ie;
  logic irq_req;
  assign irq_req  = irq && status_ie && mem_en && !sync_exc;
  assign exp_take = sync_exc || irq_req;
  assign exp_code = sync_exc ? mem_exp_code : EXP_IRQ;
`else
  assign exp_take = sync_exc;
  assign exp_code = mem_exp_code;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= ST_RESET;
    else         state <= next_state;
  end

  // Next state, stall/flush generation and SPR write strobes.
  always_comb begin
    next_state = state;
    stall_v    = 4'b0000;
    flush_v    = 4'b0000;
    flush_pc   = '0;
    exp_we     = 1'b0;
    eret_we    = 1'b0;
    ssr_we     = 1'b0;
    case (state)
      ST_RESET: begin
        flush_v    = 4'b1111;
        flush_pc   = RESET_VECTOR;
        next_state = ST_RUN;
      end
      default: begin
        if (state != ST_RUN) next_state = ST_RUN;
        if (mem_busy) begin
          stall_v = 4'b1111;
        end else if (state == ST_RUN && exp_take) begin
          flush_v    = 4'b1111;
          flush_pc   = exp_vector;
          exp_we     = 1'b1;
          next_state = ST_EXC;
        end else if (state == ST_RUN && eret_req) begin
          flush_v    = 4'b1111;
          flush_pc   = epc;
          eret_we    = 1'b1;
          next_state = ST_ERET;
        end else begin
          ssr_we = (state == ST_RUN) && ssr_req;
          if (load_use) begin
            stall_v = 4'b1100;
            flush_v = 4'b0010;
          end else if (if_busy) begin
            stall_v = 4'b1000;
            flush_v = 4'b0100;
          end
        end
      end
    endcase
  end

  assign {if_stall, id_stall, ex_stall, mem_stall} = stall_v;
  assign {if_flush, id_flush, ex_flush, mem_flush} = flush_v;

  yutorina_spr #(
    .EXP_VECTOR_INIT(EXP_VECTOR_INIT)
  ) u_spr (
    .clk        (clk),
    .reset_     (reset_),
    .exp_we     (exp_we),
    .exp_code   (exp_code),
    .exp_epc    (exp_epc),
    .eret_we    (eret_we),
    .ssr_we     (ssr_we),
    .ssr_addr   (mem_spr_addr),
    .ssr_data   (mem_spr_data),
    .r_addr     (spr_r_addr),
    .r_data     (spr_r_data),
    .mode       (mode),
`ifdef YUTORINA_IRQ_EN
    .ie         (status_ie),
`endif
    .epc        (epc),
    .exp_vector (exp_vector)
  );

endmodule
